// File: rtl/snn_inference_scheduler_pkg.sv
// Shared definitions for the SNN inference scheduler slice.
// Holds the network dimensions, the derived counter/class widths, the
// scheduler state encoding and the saturating spike-count helper.
package snn_inference_scheduler_pkg;

  localparam int INPUT_SIZE        = 16;
  localparam int PIXEL_WIDTH       = 8;
  localparam int OUTPUT_SIZE       = 4;
  localparam int SPIKE_WINDOW      = 16;
  localparam int CLOCK_DIVIDER_VAL = 8;

  localparam int PIX_W   = INPUT_SIZE * PIXEL_WIDTH;
  localparam int CNT_W   = $clog2(SPIKE_WINDOW + 1);
  localparam int CLASS_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int DIV_W   = (CLOCK_DIVIDER_VAL > 1) ? $clog2(CLOCK_DIVIDER_VAL) : 1;
  localparam int CNTS_W  = OUTPUT_SIZE * CNT_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    ARGMAX = 3'd4,
    RESULT = 3'd5
  } sched_state_e;

  // Adds one spike to a count, never exceeding the window length.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic spike);
    if (spike && (cnt < CNT_W'(SPIKE_WINDOW))) begin
      return cnt + CNT_W'(1);
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/snn_inference_scheduler_if.sv
// Image-in / result-out handshake bundle of the inference scheduler.
//   img_valid/img_ready/img_pixels : image source -> scheduler
//   res_valid/res_ready/res_class/res_none/res_counts : scheduler -> consumer
// master = host side, slave = scheduler side.
interface snn_inference_scheduler_if;
  import snn_inference_scheduler_pkg::*;

  logic               img_valid;
  logic               img_ready;
  logic [PIX_W-1:0]   img_pixels;
  logic               res_valid;
  logic               res_ready;
  logic [CLASS_W-1:0] res_class;
  logic               res_none;
  logic [CNTS_W-1:0]  res_counts;

  modport master (
    output img_valid, img_pixels, res_ready,
    input  img_ready, res_valid, res_class, res_none, res_counts
  );

  modport slave (
    input  img_valid, img_pixels, res_ready,
    output img_ready, res_valid, res_class, res_none, res_counts
  );

endinterface

// File: rtl/snn_inference_scheduler_argmax.sv
// snn_argmax: combinational argmax over packed per-neuron spike counts.
//   counts : OUTPUT_SIZE counts of CNT_W bits, neuron 0 in the LSBs
//   idx    : index of the largest count, lowest index on ties
//   none   : all counts are zero (idx is then 0)
module snn_argmax
  import snn_inference_scheduler_pkg::*;
(
  input  logic [CNTS_W-1:0]  counts,
  output logic [CLASS_W-1:0] idx,
  output logic               none
);

  logic [CNT_W-1:0] best_s;

  // Strict greater-than keeps the earliest index when counts tie.
  always_comb begin
    best_s = counts[CNT_W-1:0];
    idx    = CLASS_W'(0);
    none   = (counts == CNTS_W'(0));
    for (int i = 1; i < OUTPUT_SIZE; i++) begin
      if (counts[i*CNT_W +: CNT_W] > best_s) begin
        best_s = counts[i*CNT_W +: CNT_W];
        idx    = CLASS_W'(i);
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/snn_inference_scheduler.sv
// snn_inference_scheduler: runs one SNN inference per accepted image.
//   bus        : image handshake in, argmax result handshake out
//   pix_load   : pulse, encoder latches pix_data
//   pix_data   : registered copy of the accepted image
//   net_clear  : pulse, clear membrane potentials
//   step_en    : one time-step tick every CLOCK_DIVIDER_VAL cycles
//   out_valid/out_spikes : output-layer response for one step
//   abort      : cancel the running inference, back to IDLE
//   busy       : high outside IDLE
module snn_inference_scheduler
  import snn_inference_scheduler_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  snn_inference_scheduler_if.slave bus,
  output logic                    pix_load,
  output logic [PIX_W-1:0]        pix_data,
  output logic                    net_clear,
  output logic                    step_en,
  input  logic                    out_valid,
  input  logic [OUTPUT_SIZE-1:0]  out_spikes,
  input  logic                    abort,
  output logic                    busy
);

  sched_state_e       state_r, state_next_s;
  logic [DIV_W-1:0]   div_r;
  logic [CNT_W-1:0]   step_r;
  logic [CNT_W-1:0]   resp_r, resp_next_s;
  logic [CNTS_W-1:0]  counts_r, counts_next_s;
  logic [PIX_W-1:0]   pix_data_r;
  logic [CLASS_W-1:0] res_class_r, arg_idx_s;
  logic               res_none_r, arg_none_s;
  logic [CNTS_W-1:0]  res_counts_r;
  logic               tick_s, accept_s, resp_take_s;

  // Pulses are decoded from registered state but must be masked by abort
  // in the same cycle, so they carry a single AND of abort.
  assign tick_s      = (state_r == RUN) && (div_r == DIV_W'(CLOCK_DIVIDER_VAL - 1)) && !abort;
  assign accept_s    = (state_r == IDLE) && bus.img_valid;
  assign resp_take_s = ((state_r == RUN) || (state_r == DRAIN)) && out_valid
                       && (resp_r < CNT_W'(SPIKE_WINDOW));
  assign resp_next_s = resp_take_s ? (resp_r + CNT_W'(1)) : resp_r;

  assign bus.img_ready  = (state_r == IDLE);
  assign bus.res_valid  = (state_r == RESULT);
  assign bus.res_class  = res_class_r;
  assign bus.res_none   = res_none_r;
  assign bus.res_counts = res_counts_r;
  assign busy           = (state_r != IDLE);
  assign pix_load       = (state_r == CLEAR) && !abort;
  assign net_clear      = (state_r == CLEAR) && !abort;
  assign step_en        = tick_s;
  assign pix_data       = pix_data_r;

  snn_argmax u_argmax (
    .counts (counts_r),
    .idx    (arg_idx_s),
    .none   (arg_none_s)
  );

  // Per-neuron spike accumulation for one accepted response.
  always_comb begin
    counts_next_s = counts_r;
    if (resp_take_s) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
        counts_next_s[i*CNT_W +: CNT_W] = sat_add(counts_r[i*CNT_W +: CNT_W], out_spikes[i]);
      end
    end else begin
      counts_next_s = counts_r;
    end
  end

  // Next-state logic; abort wins in every state except IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.img_valid) state_next_s = CLEAR;
        else               state_next_s = IDLE;
      end
      CLEAR: begin
        if (abort) state_next_s = IDLE;
        else       state_next_s = RUN;
      end
      RUN: begin
        if (abort)                                                 state_next_s = IDLE;
        else if (tick_s && (step_r == CNT_W'(SPIKE_WINDOW - 1)))   state_next_s = DRAIN;
        else                                                       state_next_s = RUN;
      end
      DRAIN: begin
        // Includes a response arriving in this very cycle.
        if (abort)                                     state_next_s = IDLE;
        else if (resp_next_s == CNT_W'(SPIKE_WINDOW))  state_next_s = ARGMAX;
        else                                           state_next_s = DRAIN;
      end
      ARGMAX: begin
        if (abort) state_next_s = IDLE;
        else       state_next_s = RESULT;
      end
      RESULT: begin
        if (abort)              state_next_s = IDLE;
        else if (bus.res_ready) state_next_s = IDLE;
        else                    state_next_s = RESULT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Image capture, step pacing, spike accounting and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data_r   <= PIX_W'(0);
      div_r        <= DIV_W'(0);
      step_r       <= CNT_W'(0);
      resp_r       <= CNT_W'(0);
      counts_r     <= CNTS_W'(0);
      res_class_r  <= CLASS_W'(0);
      res_none_r   <= 1'b0;
      res_counts_r <= CNTS_W'(0);
    end else begin
      if (accept_s) begin
        pix_data_r <= bus.img_pixels;
      end

      if (state_r == CLEAR) begin
        div_r    <= DIV_W'(0);
        step_r   <= CNT_W'(0);
        resp_r   <= CNT_W'(0);
        counts_r <= CNTS_W'(0);
      end else begin
        if (state_r == RUN) begin
          div_r <= (div_r == DIV_W'(CLOCK_DIVIDER_VAL - 1)) ? DIV_W'(0) : (div_r + DIV_W'(1));
        end
        if (tick_s) begin
          step_r <= step_r + CNT_W'(1);
        end
        resp_r   <= resp_next_s;
        counts_r <= counts_next_s;
      end

      if ((state_r == ARGMAX) && !abort) begin
        res_class_r  <= arg_idx_s;
        res_none_r   <= arg_none_s;
        res_counts_r <= counts_r;
      end
    end
  end

endmodule

// File: tb/tb_snn_inference_scheduler.sv
// Self-checking bench for snn_inference_scheduler: a behavioural output
// layer answers each step_en, expected results are queued at image drive
// time and popped when res_valid appears.
module tb_snn_inference_scheduler;
  import snn_inference_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_inference_scheduler_if bus();

  logic                   pix_load, net_clear, step_en, busy;
  logic [PIX_W-1:0]       pix_data;
  logic                   out_valid;
  logic [OUTPUT_SIZE-1:0] out_spikes;
  logic                   abort;

  snn_inference_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .pix_load   (pix_load),
    .pix_data   (pix_data),
    .net_clear  (net_clear),
    .step_en    (step_en),
    .out_valid  (out_valid),
    .out_spikes (out_spikes),
    .abort      (abort),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [CNTS_W-1:0]  counts;
    logic [CLASS_W-1:0] cls;
    logic               none;
    int                 lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int                     due;
    logic [OUTPUT_SIZE-1:0] spk;
  } resp_t;
  resp_t rq[$];

  int mode = 0;
  int resp_dly = 1;
  bit extras_en = 1'b0;
  int neg_cyc = 0;
  int step_seen = 0;
  int last_step_cyc = 0;
  int spacing_bad = 0;
  int pix_load_seen = 0;
  int net_clear_seen = 0;

  function automatic logic [OUTPUT_SIZE-1:0] pattern(input int m, input int s);
    logic [OUTPUT_SIZE-1:0] p;
    p = '0;
    case (m)
      0: p = 4'b0100;
      1: p = (s % 2 == 0) ? 4'b1010 : 4'b0101;
      2: p = 4'b0000;
      3: begin
        p[0] = (s < 12);
        p[1] = (s % 2 == 1);
        p[2] = (s < 14);
        p[3] = 1'b0;
      end
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  // Output-layer model: answers each step_en resp_dly cycles later.
  initial begin
    resp_t r;
    out_valid = 1'b0;
    out_spikes = '0;
    forever begin
      @(negedge clk);
      #2;
      neg_cyc++;
      out_valid = 1'b0;
      out_spikes = '0;
      if (rq.size() > 0 && rq[0].due <= neg_cyc) begin
        r = rq.pop_front();
        out_valid = 1'b1;
        out_spikes = r.spk;
      end
      if (pix_load === 1'b1) pix_load_seen++;
      if (net_clear === 1'b1) net_clear_seen++;
      if (step_en === 1'b1) begin
        if (step_seen > 0 && (neg_cyc - last_step_cyc) != CLOCK_DIVIDER_VAL) spacing_bad++;
        last_step_cyc = neg_cyc;
        r.due = neg_cyc + resp_dly;
        r.spk = pattern(mode, step_seen);
        rq.push_back(r);
        if (extras_en && step_seen == SPIKE_WINDOW - 1) begin
          for (int k = 1; k <= 3; k++) begin
            r.due = neg_cyc + resp_dly + k;
            r.spk = 4'b1111;
            rq.push_back(r);
          end
        end
        step_seen++;
      end
    end
  end

  task automatic run_image(input int m, input int dly, input bit extras, input int bp);
    logic [PIX_W-1:0] pix;
    logic [PIX_W-1:0] other;
    logic [CNT_W-1:0] c [OUTPUT_SIZE];
    logic [CNT_W-1:0] best;
    logic [OUTPUT_SIZE-1:0] p;
    exp_t e;
    time t_acc;
    bit got;

    pix = {$urandom(), $urandom(), $urandom(), $urandom()};
    other = ~pix;
    mode = m;
    resp_dly = dly;
    extras_en = extras;
    rq.delete();
    step_seen = 0;
    spacing_bad = 0;
    pix_load_seen = 0;
    net_clear_seen = 0;

    for (int i = 0; i < OUTPUT_SIZE; i++) c[i] = '0;
    for (int s = 0; s < SPIKE_WINDOW; s++) begin
      p = pattern(m, s);
      for (int i = 0; i < OUTPUT_SIZE; i++)
        if (p[i] && c[i] < CNT_W'(SPIKE_WINDOW)) c[i] = c[i] + CNT_W'(1);
    end
    e.cls = '0;
    best = c[0];
    e.none = 1'b1;
    for (int i = 0; i < OUTPUT_SIZE; i++) begin
      e.counts[i*CNT_W +: CNT_W] = c[i];
      if (c[i] != '0) e.none = 1'b0;
      if (i > 0 && c[i] > best) begin
        best = c[i];
        e.cls = CLASS_W'(i);
      end
    end
    e.lat = 130 + dly;
    sb.push_back(e);

    @(negedge clk);
    check_eq("img_ready_idle", bus.img_ready, 1);
    bus.img_valid = 1'b1;
    bus.img_pixels = pix;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    bus.img_valid = 1'b0;

    got = 1'b0;
    for (int w = 0; w < 400 && !got; w++) begin
      if (bus.res_valid === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    e = sb.pop_front();
    if (!got) begin
      check_eq("res_valid_timeout", 0, 1);
      return;
    end

    check_eq("latency", 64'(($time - t_acc - 5) / 10), 64'(e.lat));
    check_eq("res_counts", bus.res_counts, e.counts);
    check_eq("res_class", bus.res_class, e.cls);
    check_eq("res_none", bus.res_none, e.none);
    check_eq("step_count", step_seen, SPIKE_WINDOW);
    check_eq("step_spacing_bad", spacing_bad, 0);
    check_eq("pix_load_pulses", pix_load_seen, 1);
    check_eq("net_clear_pulses", net_clear_seen, 1);
    check_eq("pix_data_lo", pix_data[63:0], pix[63:0]);
    check_eq("pix_data_hi", pix_data[127:64], pix[127:64]);
    check_eq("img_ready_result", bus.img_ready, 0);
    check_eq("busy_result", busy, 1);

    if (bp > 0) begin
      bus.img_valid = 1'b1;
      bus.img_pixels = other;
      repeat (bp) begin
        @(negedge clk);
        check_eq("bp_res_valid", bus.res_valid, 1);
        check_eq("bp_img_ready", bus.img_ready, 0);
        check_eq("bp_counts", bus.res_counts, e.counts);
        check_eq("bp_class", bus.res_class, e.cls);
        check_eq("bp_none", bus.res_none, e.none);
      end
      bus.img_valid = 1'b0;
    end

    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_eq("res_valid_after_ack", bus.res_valid, 0);
    check_eq("img_ready_after_ack", bus.img_ready, 1);
    check_eq("busy_after_ack", busy, 0);
    check_eq("pix_data_kept", pix_data[63:0], pix[63:0]);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_rv;
    bit got4;
    bus.img_valid = 1'b0;
    bus.img_pixels = '0;
    bus.res_ready = 1'b0;
    abort = 1'b0;

    #12;
    check_eq("rst_img_ready", bus.img_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_step_en", step_en, 0);
    check_eq("rst_pix_load", pix_load, 0);
    check_eq("rst_pix_data", pix_data[63:0], 0);
    check_eq("rst_res_counts", bus.res_counts, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_image(0, 1, 1'b0, 0);   // nominal: class 2, counts {0,16,0,0}
    run_image(1, 1, 1'b0, 0);   // tie: all counts 8, class 0
    run_image(2, 1, 1'b0, 0);   // no spikes: res_none
    run_image(0, 1, 1'b0, 50);  // result backpressure
    run_image(3, 10, 1'b1, 0);  // late responses plus extras

    // Abort on the 5th tick.
    mode = 0; resp_dly = 1; extras_en = 1'b0; rq.delete();
    step_seen = 0;
    @(negedge clk);
    bus.img_valid = 1'b1;
    bus.img_pixels = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    bus.img_valid = 1'b0;
    got4 = 1'b0;
    for (int w = 0; w < 200 && !got4; w++) begin
      @(negedge clk);
      if (step_seen == 4) got4 = 1'b1;
    end
    check_eq("abort_reach_step4", got4, 1);
    repeat (CLOCK_DIVIDER_VAL - 1) @(negedge clk);
    abort = 1'b1;
    #1;
    check_eq("abort_step_suppressed", step_en, 0);
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_img_ready", bus.img_ready, 1);
    seen_rv = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) seen_rv = 1'b1;
    end
    check_eq("abort_no_result", seen_rv, 0);
    check_eq("abort_steps", step_seen, 4);
    run_image(0, 1, 1'b0, 0);   // clean run after abort

    // Asynchronous reset mid-RUN, off the clock edge.
    mode = 0; resp_dly = 1; rq.delete();
    @(negedge clk);
    bus.img_valid = 1'b1;
    @(negedge clk);
    bus.img_valid = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("pre_reset_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("areset_img_ready", bus.img_ready, 1);
    check_eq("areset_busy", busy, 0);
    check_eq("areset_step_en", step_en, 0);
    check_eq("areset_res_counts", bus.res_counts, 0);
    check_eq("areset_pix_data", pix_data[63:0], 0);
    #13;
    rst_n = 1'b1;
    step_seen = 0;
    repeat (40) @(negedge clk);
    check_eq("post_reset_no_steps", step_seen, 0);
    check_eq("post_reset_img_ready", bus.img_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snn_inference_scheduler.md
Name: snn_inference_scheduler

Overview:
Sequences one inference of the two-layer SNN per accepted image. Accepts a pixel vector, clears the network state, and issues SPIKE_WINDOW time-step ticks paced by a CLOCK_DIVIDER_VAL divider. It counts output-layer spikes per output neuron, then returns an argmax class over a valid/ready result interface. It sits between the host/DMA image source and the rate encoder plus hidden/output layers.

Parameters:
INPUT_SIZE, 16, number of pixels per image
PIXEL_WIDTH, 8, bits per pixel
OUTPUT_SIZE, 4, output-layer neuron count (classes)
SPIKE_WINDOW, 16, time steps per inference
CLOCK_DIVIDER_VAL, 8, clk cycles per time step (minimum 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
img_valid  in  1  image available
img_ready  out  1  scheduler can accept an image
img_pixels  in  INPUT_SIZE*PIXEL_WIDTH  packed pixels, pixel 0 in LSBs
pix_load  out  1  one-cycle pulse: encoder latches pix_data
pix_data  out  INPUT_SIZE*PIXEL_WIDTH  registered copy of accepted pixels
net_clear  out  1  one-cycle pulse: clear membrane potentials
step_en  out  1  one-cycle time-step tick to encoder and layers
out_valid  in  1  out_spikes valid for one completed step
out_spikes  in  OUTPUT_SIZE  output-layer spike vector
abort  in  1  synchronous cancel of the current inference
res_valid  out  1  result available
res_ready  in  1  result consumed
res_class  out  CLASS_W  winning output index
res_none  out  1  no output spikes in the whole window
res_counts  out  OUTPUT_SIZE*CNT_W  per-neuron spike counts
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0. Exception: img_ready=1 (IDLE). Counters and pix_data are cleared.
- Widths: CNT_W=$clog2(SPIKE_WINDOW+1); CLASS_W=max(1,$clog2(OUTPUT_SIZE)).
- FSM states: IDLE, CLEAR, RUN, DRAIN, ARGMAX, RESULT.
- IDLE: img_ready=1. On img_valid&&img_ready, register pixels into pix_data and go to CLEAR.
- CLEAR (1 cycle): pix_load=1 and net_clear=1. Spike counts, step counter, response counter and divider are zeroed. Next state RUN.
- RUN: the divider counts 0..CLOCK_DIVIDER_VAL-1 and wraps. step_en=1 in the cycle the divider equals CLOCK_DIVIDER_VAL-1, so the first tick is on the CLOCK_DIVIDER_VAL-th RUN cycle. The step counter increments per tick. On the SPIKE_WINDOW-th tick, go to DRAIN. RUN lasts exactly SPIKE_WINDOW*CLOCK_DIVIDER_VAL cycles (128 by default).
- Spike accounting in RUN/DRAIN: each cycle with out_valid=1 does the following.
  - Increments the response counter.
  - Adds out_spikes[i] to count[i], saturating at SPIKE_WINDOW.
  - Responses beyond SPIKE_WINDOW are ignored.
  - out_valid in any other state is ignored.
- DRAIN: wait until the response counter equals SPIKE_WINDOW, then go to ARGMAX. A response arriving in the same cycle as the RUN→DRAIN transition is counted.
- ARGMAX (1 cycle): res_class = index of the maximum count; the lowest index wins ties. res_none=1 if all counts are 0, with res_class=0. res_counts is registered. Next state RESULT.
- RESULT: res_valid=1; res_class, res_none and res_counts are held stable until res_ready. On res_valid&&res_ready, go to IDLE with res_valid=0 the next cycle. img_ready stays 0 during RESULT, so there is no overlap of result and next image.
- abort: in any non-IDLE state, the next state is IDLE; res_valid drops and no result is produced. step_en, pix_load and net_clear are never asserted in the cycle abort is high. In IDLE, abort has no effect; img_valid&&abort in IDLE still accepts the image.
- Reset mid-operation returns to the reset state immediately; no partial result.
- Latency from image accept to res_valid: 1 + 1 + SPIKE_WINDOW*CLOCK_DIVIDER_VAL + drain + 1 cycles. With prompt responses this is 131 cycles at defaults.

Decomposition:
- network_pkg gains:
  - typedef enum logic [2:0] sched_state_e {IDLE, CLEAR, RUN, DRAIN, ARGMAX, RESULT}
  - localparams CNT_W and CLASS_W derived from SPIKE_WINDOW/OUTPUT_SIZE
  - reuses INPUT_SIZE, PIXEL_WIDTH, OUTPUT_SIZE, SPIKE_WINDOW, CLOCK_DIVIDER_VAL
- One combinational sub-module, snn_argmax: inputs packed counts; outputs index and none flag; lowest index wins ties.

Test Plan:
- Nominal: image accepted, out_valid one cycle after each step_en with out_spikes=4'b0100 every step → exactly 16 step_en, 8 cycles apart; res_counts={0,16,0,0}, res_class=2, res_none=0, res_valid 131 cycles after accept.
- Tie and zero: out_spikes alternates 4'b1010/4'b0101 → counts all 8, res_class=0. All-zero spikes → res_none=1, res_class=0.
- Backpressure: hold res_ready=0 for 50 cycles → res_valid and outputs stable, img_ready=0, and img_valid ignored. Release → IDLE next cycle; img_ready=1.
- Late responses: delay each out_valid by 10 cycles so the last arrives in DRAIN; send 3 extra out_valid → counts include exactly 16 responses and extras are ignored.
- Abort: assert abort on the 5th step_en cycle → that step_en is suppressed, state IDLE next cycle, no res_valid; the next image runs cleanly with counts restarting from 0.
- Async reset: drop rst_n mid-RUN, off a clock edge → outputs clear immediately with img_ready=1 after release; no step_en until a new image is accepted.
